// File: rtl/dcache_miss_ctrl.sv
// Miss sequencer for the two-way data cache: optional dirty-victim write-back, line refill, tag install.
// Optional performance counters are enabled with `define DCACHE_MISS_CTRL_PERF_EN.
//
// state    | meaning
// IDLE     | no miss in flight; a miss without flush starts a sequence
// WB_REQ   | write-back address phase, victim line address on the bus
// WB_DATA  | streaming victim beats to memory
// WB_RESP  | waiting for the write response
// RF_REQ   | refill address phase, missing line address on the bus
// RF_DATA  | writing returned beats into the data array
// REFRESH  | one-cycle tag install / LRU flip
module dcache_miss_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              miss,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [DATA_W-1:0] victim_rdata,
  output logic [2:0]        victim_beat,
  output logic              stallreq,
  output logic              refill_we,
  output logic [2:0]        refill_beat,
  output logic [DATA_W-1:0] refill_data,
  output logic              refresh,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  output logic              mem_wlast,
  input  logic              mem_wready,
  input  logic              mem_bvalid,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_MISS_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_miss_cnt,
  output logic [31:0]       perf_wb_cnt
`endif
);

  localparam int              OFF_W     = 3 + $clog2(LINE_BEATS);
  localparam logic [2:0]      LAST_BEAT = 3'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_DATA, WB_RESP, RF_REQ, RF_DATA, REFRESH
  } state_t;

  state_t            state;
  logic [2:0]        beat_cnt;
  logic [ADDR_W-1:0] cpu_line;
  logic [ADDR_W-1:0] victim_line;
  logic              start;
  logic              last_beat;

  assign start     = miss & ~flush;
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      cpu_line    <= '0;
      victim_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cpu_line    <= cpu_addr;
            victim_line <= victim_addr;
            beat_cnt    <= '0;
            state       <= write_back ? WB_REQ : RF_REQ;
          end
        end
        WB_REQ:  if (mem_gnt) state <= WB_DATA;
        WB_DATA: begin
          if (mem_wready) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= WB_RESP;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        WB_RESP: if (mem_bvalid) state <= RF_REQ;
        RF_REQ:  if (mem_gnt) state <= RF_DATA;
        RF_DATA: begin
          if (mem_rvalid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= REFRESH;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        REFRESH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_MISS_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else if (state == IDLE && start) begin
      if (perf_miss_cnt != 32'hFFFF_FFFF) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (write_back && perf_wb_cnt != 32'hFFFF_FFFF) perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
  end
`endif

  // Outputs decode the registered state; buses are forced to zero outside their phase.
  always_comb begin
    stallreq    = (state != IDLE) | start;
    victim_beat = '0;
    refill_we   = 1'b0;
    refill_beat = '0;
    refill_data = '0;
    refresh     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wvalid  = 1'b0;
    mem_wlast   = 1'b0;
    case (state)
      WB_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = victim_line & LINE_MASK;
      end
      WB_DATA: begin
        mem_wvalid  = 1'b1;
        mem_wdata   = victim_rdata;
        mem_wlast   = last_beat;
        victim_beat = beat_cnt;
      end
      RF_REQ: begin
        mem_req  = 1'b1;
        mem_addr = cpu_line & LINE_MASK;
      end
      RF_DATA: begin
        if (mem_rvalid) begin
          refill_we   = 1'b1;
          refill_beat = beat_cnt;
          refill_data = mem_rdata;
        end
      end
      REFRESH: refresh = 1'b1;
      default: ;
    endcase
  end

endmodule
